// File: rtl/stack_seq_ctrl_if.sv
// ============================================================================
// Module   : stack_seq_ctrl_if
// Purpose  : Core-op, stack-control, FILL/DUMP and status bundle of stack_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stack_seq_ctrl_if #(
    parameter int DW = 5
);
    logic [1:0]    core_op;
    logic [15:0]   core_wd;
    logic          core_stall;
    logic          stk_we;
    logic [1:0]    stk_delta;
    logic [15:0]   stk_wd;
    logic [15:0]   stk_rd;
    logic          fill_req;
    logic [15:0]   fill_val;
    logic          dump_req;
    logic [15:0]   dump_data;
    logic          dump_valid;
    logic          dump_ready;
    logic          dump_last;
    logic          busy;
    logic [DW-1:0] depth;
    logic [DW-1:0] hiwater;
    logic          ovf;
    logic          unf;
    logic          clr_flags;

    modport slave (
        input  core_op, core_wd, stk_rd, fill_req, fill_val,
               dump_req, dump_ready, clr_flags,
        output core_stall, stk_we, stk_delta, stk_wd, dump_data,
               dump_valid, dump_last, busy, depth, hiwater, ovf, unf
    );

    modport master (
        output core_op, core_wd, stk_rd, fill_req, fill_val,
               dump_req, dump_ready, clr_flags,
        input  core_stall, stk_we, stk_delta, stk_wd, dump_data,
               dump_valid, dump_last, busy, depth, hiwater, ovf, unf
    );
endinterface

`default_nettype wire

// File: rtl/stack_seq_ctrl.sv
// ============================================================================
// Module   : stack_seq_ctrl
// Purpose  : Op sequencer, depth/flag guard and FILL/DUMP engine for one J1a stack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_seq_ctrl #(
    parameter int DEPTH = 18,
    parameter int DW    = $clog2(DEPTH + 2)
) (
    input  logic            clk,
    input  logic            resetq,
    stack_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DUMP = 2'd2
    } state_e;

    localparam logic [1:0]    OP_PUSH = 2'b01;
    localparam logic [1:0]    OP_REPL = 2'b10;
    localparam logic [1:0]    OP_POP  = 2'b11;
    localparam logic [DW-1:0] CAP     = DW'(DEPTH + 1);
    localparam logic [DW-1:0] ONE     = DW'(1);

    state_e        state_q, state_d;
    logic [DW-1:0] k_q, k_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [DW-1:0] hiwater_q, hiwater_d;
    logic [15:0]   pattern_q, pattern_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic          ovf_set;
    logic          unf_set;
    logic          we;
    logic [1:0]    delta;
    logic [15:0]   wd;
    logic          dvalid;
    logic          dlast;

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            depth_q   <= '0;
            hiwater_q <= '0;
            pattern_q <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            depth_q   <= depth_d;
            hiwater_q <= hiwater_d;
            pattern_q <= pattern_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        depth_d   = depth_q;
        pattern_d = pattern_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        we        = 1'b0;
        delta     = 2'b00;
        wd        = bus.core_wd;
        dvalid    = 1'b0;
        dlast     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Boundary ops still reach the stack; only the counter saturates.
                case (bus.core_op)
                    OP_PUSH: begin
                        we    = 1'b1;
                        delta = 2'b01;
                        if (depth_q == CAP) ovf_set = 1'b1;
                        else                depth_d = depth_q + ONE;
                    end
                    OP_REPL: begin
                        we = 1'b1;
                        if (depth_q == '0) depth_d = ONE;
                    end
                    OP_POP: begin
                        delta = 2'b11;
                        if (depth_q == '0) unf_set = 1'b1;
                        else               depth_d = depth_q - ONE;
                    end
                    default: ;
                endcase

                if (bus.fill_req) begin
                    state_d   = S_FILL;
                    pattern_d = bus.fill_val;
                    k_d       = '0;
                end else if (bus.dump_req) begin
                    state_d = S_DUMP;
                end
            end

            S_FILL: begin
                we    = 1'b1;
                delta = 2'b01;
                wd    = pattern_q;
                if (k_q == CAP - ONE) begin
                    state_d = S_IDLE;
                    depth_d = '0;
                end else begin
                    k_d = k_q + ONE;
                end
            end

            S_DUMP: begin
                if (depth_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    dvalid = 1'b1;
                    dlast  = (depth_q == ONE);
                    if (bus.dump_ready) begin
                        delta   = 2'b11;
                        depth_d = depth_q - ONE;
                        if (dlast) state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A fresh event beats a coincident clear.
        ovf_d     = ovf_set | (ovf_q & ~bus.clr_flags);
        unf_d     = unf_set | (unf_q & ~bus.clr_flags);
        hiwater_d = bus.clr_flags        ? depth_d :
                    (depth_d > hiwater_q) ? depth_d : hiwater_q;
    end

    // Reset gates every stack-moving output so an abort cannot shift the stack.
    assign bus.stk_we     = we & resetq;
    assign bus.stk_delta  = resetq ? delta : 2'b00;
    assign bus.stk_wd     = wd;
    assign bus.dump_valid = dvalid & resetq;
    assign bus.dump_last  = dlast & resetq;
    assign bus.dump_data  = bus.stk_rd;
    assign bus.busy       = (state_q != S_IDLE) & resetq;
    assign bus.core_stall = bus.busy;
    assign bus.depth      = depth_q;
    assign bus.hiwater    = hiwater_q;
    assign bus.ovf        = ovf_q;
    assign bus.unf        = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_seq_ctrl.sv
// ============================================================================
// Module   : tb_stack_seq_ctrl
// Purpose  : Self-checking bench for stack_seq_ctrl with a shift-register stack model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_seq_ctrl;

    localparam int DEPTH = 18;
    localparam int CAP   = DEPTH + 1;
    localparam int DW    = $clog2(DEPTH + 2);

    logic clk    = 1'b0;
    logic resetq = 1'b0;
    always #5 clk = ~clk;

    stack_seq_ctrl_if #(.DW(DW)) bus ();

    stack_seq_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Physical shift-register stack the controller drives.
    logic [15:0] cells [CAP];
    int          n_push = 0;
    int          n_pop  = 0;
    int          n_badpat = 0;
    logic [15:0] exp_pat = 16'h0;

    always @(posedge clk) begin
        if (bus.stk_delta == 2'b01) begin
            for (int i = CAP - 1; i > 0; i--) cells[i] <= cells[i-1];
            cells[0] <= bus.stk_wd;
            n_push   <= n_push + 1;
            if (bus.stk_wd !== exp_pat) n_badpat <= n_badpat + 1;
        end else if (bus.stk_delta == 2'b11) begin
            for (int i = 0; i < CAP - 1; i++) cells[i] <= cells[i+1];
            n_pop <= n_pop + 1;
        end else if (bus.stk_we) begin
            cells[0] <= bus.stk_wd;
        end
    end
    assign bus.stk_rd = cells[0];

    // Reference model: logical contents (top first), depth and flags.
    logic [15:0] m_stack [$];
    int          m_depth;
    int          m_hi;
    bit          m_ovf;
    bit          m_unf;
    logic        obs_we;
    logic [1:0]  obs_delta;

    task automatic model_op(input logic [1:0] op, input logic [15:0] wd, input bit clr);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        case (op)
            2'b01: begin
                if (m_depth == CAP) m_ovf = 1'b1;
                else                m_depth++;
                m_stack.push_front(wd);
                if (m_stack.size() > CAP) void'(m_stack.pop_back());
            end
            2'b10: begin
                if (m_depth == 0) begin
                    m_depth = 1;
                    m_stack.push_front(wd);
                end else begin
                    m_stack[0] = wd;
                end
            end
            2'b11: begin
                if (m_depth == 0) m_unf = 1'b1;
                else begin
                    m_depth--;
                    void'(m_stack.pop_front());
                end
            end
            default: ;
        endcase
        if (clr)               m_hi = m_depth;
        else if (m_depth > m_hi) m_hi = m_depth;
    endtask

    task automatic step(input logic [1:0] op, input logic [15:0] wd, input bit clr);
        bus.core_op   = op;
        bus.core_wd   = wd;
        bus.clr_flags = clr;
        exp_pat       = wd;
        @(negedge clk);
        obs_we    = bus.stk_we;
        obs_delta = bus.stk_delta;
        model_op(op, wd, clr);
        @(posedge clk);
        #1;
        bus.core_op   = 2'b00;
        bus.clr_flags = 1'b0;
    endtask

    task automatic apply_reset();
        resetq         = 1'b0;
        bus.core_op    = 2'b00;
        bus.core_wd    = '0;
        bus.fill_req   = 1'b0;
        bus.fill_val   = '0;
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b0;
        bus.clr_flags  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetq  = 1'b1;
        m_stack.delete();
        m_depth = 0;
        m_hi    = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic test_reset();
        resetq       = 1'b0;
        bus.core_op  = 2'b01;
        bus.dump_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.stk_we, bus.stk_delta, bus.dump_valid, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: we/delta/valid/busy=%b expected 00000",
                     {bus.stk_we, bus.stk_delta, bus.dump_valid, bus.busy});
        end
        apply_reset();
        checks++;
        if (bus.depth !== '0 || bus.hiwater !== '0 || bus.ovf !== 1'b0 || bus.unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: depth=%0d hi=%0d ovf=%b unf=%b expected 0 0 0 0",
                     bus.depth, bus.hiwater, bus.ovf, bus.unf);
        end
    endtask

    task automatic test_basic();
        logic [15:0] vals [3];
        logic [1:0]  dseq [4];
        vals = '{16'h1111, 16'h2222, 16'h3333};
        dseq = '{2'b01, 2'b01, 2'b01, 2'b11};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(2'b01, vals[i], 1'b0);
            else       step(2'b11, 16'h0, 1'b0);
            checks++;
            if (obs_delta !== dseq[i]) begin
                errors++;
                $display("FAIL basic_delta[%0d]: got %b expected %b", i, obs_delta, dseq[i]);
            end
            checks++;
            if (bus.depth !== DW'(i < 3 ? i + 1 : 2)) begin
                errors++;
                $display("FAIL basic_depth[%0d]: got %0d expected %0d", i, bus.depth, i < 3 ? i + 1 : 2);
            end
        end
        checks++;
        if (bus.stk_rd !== 16'h2222 || bus.hiwater !== DW'(3)) begin
            errors++;
            $display("FAIL basic_top_hi: top=%h hi=%0d expected 2222 3", bus.stk_rd, bus.hiwater);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            step(2'b01, 16'(i), 1'b0);
            checks++;
            if (bus.depth !== DW'(i > CAP ? CAP : i) || bus.ovf !== (i > CAP)) begin
                errors++;
                $display("FAIL ovf_push[%0d]: depth=%0d ovf=%b expected %0d %b",
                         i, bus.depth, bus.ovf, i > CAP ? CAP : i, i > CAP);
            end
        end
        checks++;
        if (obs_delta !== 2'b01 || bus.stk_rd !== 16'd20) begin
            errors++;
            $display("FAIL ovf_issued: delta=%b top=%h expected 01 0014", obs_delta, bus.stk_rd);
        end
        step(2'b00, 16'h0, 1'b1);
        checks++;
        if (bus.ovf !== 1'b0 || bus.hiwater !== DW'(CAP)) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b hi=%0d expected 0 %0d", bus.ovf, bus.hiwater, CAP);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        step(2'b11, 16'h0, 1'b0);
        checks++;
        if (bus.unf !== 1'b1 || bus.depth !== '0 || obs_delta !== 2'b11) begin
            errors++;
            $display("FAIL unf_pop: unf=%b depth=%0d delta=%b expected 1 0 11", bus.unf, bus.depth, obs_delta);
        end
        step(2'b11, 16'h0, 1'b1);
        checks++;
        if (bus.unf !== 1'b1) begin
            errors++;
            $display("FAIL unf_set_wins: unf=%b expected 1", bus.unf);
        end
        step(2'b00, 16'h0, 1'b1);
        checks++;
        if (bus.unf !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear: unf=%b expected 0", bus.unf);
        end
        step(2'b10, 16'hBEEF, 1'b0);
        checks++;
        if (bus.depth !== DW'(1) || bus.stk_rd !== 16'hBEEF || obs_we !== 1'b1 || obs_delta !== 2'b00) begin
            errors++;
            $display("FAIL replace_empty: depth=%0d top=%h we=%b delta=%b expected 1 beef 1 00",
                     bus.depth, bus.stk_rd, obs_we, obs_delta);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        bit         clr;
        int         bad = 0;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            // Bias towards pushes early and pops late to hit both saturation points.
            op  = (i < 150) ? (($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom))
                            : (($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom));
            clr = ($urandom_range(0, 7) == 0);
            step(op, 16'($urandom), clr);
            checks++;
            if (obs_delta !== (op == 2'b10 ? 2'b00 : op) || obs_we !== (op == 2'b01 || op == 2'b10)) begin
                errors++; bad++;
                $display("FAIL rand_ctrl[%0d]: op=%b we=%b delta=%b", i, op, obs_we, obs_delta);
            end
            checks++;
            if (bus.depth !== DW'(m_depth) || bus.hiwater !== DW'(m_hi) ||
                bus.ovf !== m_ovf || bus.unf !== m_unf) begin
                errors++; bad++;
                $display("FAIL rand_state[%0d]: depth=%0d hi=%0d ovf=%b unf=%b expected %0d %0d %b %b",
                         i, bus.depth, bus.hiwater, bus.ovf, bus.unf, m_depth, m_hi, m_ovf, m_unf);
            end
            if (m_depth > 0) begin
                checks++;
                if (bus.stk_rd !== m_stack[0]) begin
                    errors++; bad++;
                    $display("FAIL rand_top[%0d]: got %h expected %h", i, bus.stk_rd, m_stack[0]);
                end
            end
            if (bad > 10) break;
        end
    endtask

    task automatic test_fill();
        int nbusy = 0;
        int push0;
        int bad0;
        bit done = 1'b0;
        bit ovf0;
        int hi0;
        step(2'b01, 16'h1234, 1'b0);
        ovf0 = m_ovf;
        hi0  = m_hi;
        bus.fill_val = 16'h55AA;
        bus.fill_req = 1'b1;
        @(posedge clk);
        #1;
        bus.fill_req = 1'b0;
        exp_pat      = 16'h55AA;
        push0        = n_push;
        bad0         = n_badpat;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            nbusy++;
            bus.core_op = 2'b01;
            bus.core_wd = 16'($urandom);
            @(posedge clk);
            #1;
            bus.core_op = 2'b00;
        end
        @(posedge clk);
        #1;
        m_stack.delete();
        m_depth = 0;
        checks++;
        if (!done || nbusy != CAP) begin
            errors++;
            $display("FAIL fill_busy: busy cycles=%0d expected %0d", nbusy, CAP);
        end
        checks++;
        if (n_push - push0 != CAP || n_badpat != bad0) begin
            errors++;
            $display("FAIL fill_pushes: pushes=%0d badpattern=%0d expected %0d 0",
                     n_push - push0, n_badpat - bad0, CAP);
        end
        checks++;
        if (bus.depth !== '0 || bus.ovf !== ovf0 || bus.hiwater !== DW'(hi0) || bus.stk_rd !== 16'h55AA) begin
            errors++;
            $display("FAIL fill_after: depth=%0d ovf=%b hi=%0d top=%h expected 0 %b %0d 55aa",
                     bus.depth, bus.ovf, bus.hiwater, bus.stk_rd, ovf0, hi0);
        end
    endtask

    task automatic test_dump();
        logic       rdy [4];
        logic [15:0] exp_d;
        logic        exp_l;
        rdy = '{1'b1, 1'b0, 1'b1, 1'b1};
        apply_reset();
        bus.dump_req = 1'b1;
        @(posedge clk);
        #1;
        bus.dump_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_empty: busy=%b valid=%b expected 1 0", bus.busy, bus.dump_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL dump_empty_exit: busy=%b expected 0", bus.busy);
        end
        @(posedge clk);
        #1;
        step(2'b01, 16'h000A, 1'b0);
        step(2'b01, 16'h000B, 1'b0);
        step(2'b01, 16'h000C, 1'b0);
        bus.dump_req = 1'b1;
        @(posedge clk);
        #1;
        bus.dump_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.dump_ready = rdy[i];
            @(negedge clk);
            exp_d = m_stack[0];
            exp_l = (m_depth == 1);
            checks++;
            if (bus.dump_valid !== 1'b1 || bus.dump_data !== exp_d || bus.dump_last !== exp_l ||
                bus.stk_delta !== (rdy[i] ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL dump_beat[%0d]: valid=%b data=%h last=%b delta=%b expected 1 %h %b %b",
                         i, bus.dump_valid, bus.dump_data, bus.dump_last, bus.stk_delta,
                         exp_d, exp_l, rdy[i] ? 2'b11 : 2'b00);
            end
            if (rdy[i]) begin
                void'(m_stack.pop_front());
                m_depth--;
            end
            @(posedge clk);
            #1;
        end
        bus.dump_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.depth !== '0 || bus.busy !== 1'b0 || bus.dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_done: depth=%0d busy=%b valid=%b expected 0 0 0",
                     bus.depth, bus.busy, bus.dump_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_dump();
        int pop0;
        apply_reset();
        step(2'b01, 16'h0101, 1'b0);
        step(2'b01, 16'h0202, 1'b0);
        step(2'b01, 16'h0303, 1'b0);
        bus.dump_req   = 1'b1;
        @(posedge clk);
        #1;
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b1;
        @(posedge clk);
        #1;
        pop0   = n_pop;
        resetq = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stk_delta !== 2'b00 || bus.dump_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_dump_gate: delta=%b valid=%b busy=%b expected 00 0 0",
                     bus.stk_delta, bus.dump_valid, bus.busy);
        end
        @(posedge clk);
        #1;
        resetq = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.depth !== '0 || bus.dump_valid !== 1'b0 || n_pop != pop0) begin
            errors++;
            $display("FAIL rst_dump_after: busy=%b depth=%0d valid=%b extra_pops=%0d expected 0 0 0 0",
                     bus.busy, bus.depth, bus.dump_valid, n_pop - pop0);
        end
        bus.dump_ready = 1'b0;
    endtask

    initial begin
        bus.core_op    = 2'b00;
        bus.core_wd    = '0;
        bus.fill_req   = 1'b0;
        bus.fill_val   = '0;
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b0;
        bus.clr_flags  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_random();
        test_fill();
        test_dump();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
